// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: bit-serial a - b - bin, LSB first, one bit per
// clock through a single borrow flip-flop. IDLE -> SHIFT (WIDTH cycles) ->
// DONE (one cycle). Results and flags hold until the next DONE.
// Optional macro SERIAL_SUB_SAT_EN: unsigned saturation to zero on underflow.
module serial_subtractor_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    // WIDTH=1 still needs a one-bit counter so the port widths stay legal
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, res, res_nx;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d, amsb, bmsb, last;

    // One-bit full-subtractor slice and the result shifted in from the MSB side
    always_comb begin
        d      = sa[0] ^ sb[0] ^ br;
        br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_nx = res >> 1;
        res_nx[WIDTH-1] = d;
        last   = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE:  begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers, borrow FF, counter and held result/flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            amsb <= 1'b0;
            bmsb <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa   <= a;
                    sb   <= b;
                    br   <= bin;
                    res  <= '0;
                    cnt  <= '0;
                    // operand MSBs are consumed by the shift, keep them for ovf
                    amsb <= a[WIDTH-1];
                    bmsb <= b[WIDTH-1];
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    res <= res_nx;
                    cnt <= cnt + CW'(1);
                    // final bit: publish the result so it is valid during DONE
                    if (last) begin
                        diff <= res_nx;
                        bout <= br_nx;
                        zero <= (res_nx == '0);
                        ovf  <= (amsb != bmsb) && (res_nx[WIDTH-1] != amsb);
`ifdef SERIAL_SUB_SAT_EN
                        if (br_nx) begin
                            diff <= '0;
                            zero <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
